// File: rtl/accum_bank_array.sv
// Bank of NUM_COLS accumulator columns sharing one address. Ops go through a two-stage
// read-modify-write pipeline over a sync-read memory, with a full-array clear sweep.
//
// state  | meaning
// IDLE   | accepting ops and drains
// CLEAR  | writing zero to one address per cycle; all requests ignored
module accum_bank_array #(
   parameter int NUM_COLS   = 16,
   parameter int DEPTH_LOG2 = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int SATURATE   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [DEPTH_LOG2-1:0]         in_addr,
   input  logic                          in_mode,
   input  logic [NUM_COLS*ACC_WIDTH-1:0] in_psum,
   input  logic                          rd_req,
   input  logic [DEPTH_LOG2-1:0]         rd_addr,
   input  logic                          rd_clear,
   input  logic                          clr_all,
   output logic                          rd_ready,
   output logic                          busy,
   output logic                          out_valid,
   output logic [NUM_COLS*ACC_WIDTH-1:0] out_data,
   output logic                          sat_flag
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int DW    = NUM_COLS * ACC_WIDTH;
   localparam logic [DEPTH_LOG2-1:0] TOP_ADDR = '1;
   localparam logic [ACC_WIDTH-1:0]  ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0]  ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   sweep_q, sweep_d;
   logic                    sweep_we, clr_start;

   logic [DW-1:0]           mem_q [DEPTH];
   logic [DW-1:0]           mem_rdata_q;
   logic                    mem_we;
   logic [DEPTH_LOG2-1:0]   mem_waddr;
   logic [DW-1:0]           mem_wdata;

   logic                    accept_op, accept_rd;
   logic                    s0_valid_q, s0_drain_q, s0_clear_q, s0_mode_q;
   logic [DEPTH_LOG2-1:0]   s0_addr_q;
   logic [DW-1:0]           s0_psum_q;
   logic                    s1_valid_q, s1_drain_q, s1_clear_q, s1_mode_q;
   logic [DEPTH_LOG2-1:0]   s1_addr_q;
   logic [DW-1:0]           s1_psum_q;

   logic                    fwd_q, fwd_d;
   logic [DW-1:0]           fwd_data_q;
   logic [DW-1:0]           old_data, s1_wdata;
   logic [NUM_COLS-1:0]     col_sat;
   logic                    s1_we, sat_event;

   logic                    out_valid_q, out_valid_d;
   logic [DW-1:0]           out_data_q;
   logic                    sat_q;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_all) begin
               state_d = ST_CLEAR;
               sweep_d = '0;
            end
         end
         ST_CLEAR: begin
            // counter parks at the top address rather than wrapping
            if (sweep_q == TOP_ADDR) state_d = ST_IDLE;
            else                     sweep_d = sweep_q + 1'b1;
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_comb begin
      busy      = (state_q == ST_CLEAR);
      sweep_we  = (state_q == ST_CLEAR);
      clr_start = (state_q == ST_IDLE) && clr_all;
   end

   // ---------------- request stage (S0) ----------------
   assign rd_ready  = !in_valid && !busy;
   assign accept_op = in_valid && !busy;
   assign accept_rd = rd_req && rd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid_q <= 1'b0;
         s1_valid_q <= 1'b0;
         fwd_q      <= 1'b0;
      end else begin
         s0_valid_q <= accept_op || accept_rd;
         s1_valid_q <= s0_valid_q;
         fwd_q      <= fwd_d;
      end
   end

   always_ff @(posedge clk) begin
      s0_drain_q <= accept_rd;
      s0_clear_q <= rd_clear;
      s0_mode_q  <= in_mode;
      s0_addr_q  <= accept_op ? in_addr : rd_addr;
      s0_psum_q  <= accept_op ? in_psum : '0;
      s1_drain_q <= s0_drain_q;
      s1_clear_q <= s0_clear_q;
      s1_mode_q  <= s0_mode_q;
      s1_addr_q  <= s0_addr_q;
      s1_psum_q  <= s0_psum_q;
      fwd_data_q <= s1_wdata;
   end

   // ---------------- memory ----------------
   assign mem_we    = sweep_we || s1_we;
   assign mem_waddr = sweep_we ? sweep_q : s1_addr_q;
   assign mem_wdata = sweep_we ? '0 : s1_wdata;

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
      mem_rdata_q <= mem_q[s0_addr_q];
   end

   // ---------------- compute/write stage (S1) ----------------
   // The memory read races the S1 write at the same edge, so a same-address hit
   // captures the S1 value alongside and selects it here.
   assign fwd_d    = s0_valid_q && s1_we && (s1_addr_q == s0_addr_q);
   assign old_data = fwd_q ? fwd_data_q : mem_rdata_q;

   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      logic [ACC_WIDTH-1:0] a, b, sum;
      logic                 ovf;
      assign a   = old_data[c*ACC_WIDTH +: ACC_WIDTH];
      assign b   = s1_psum_q[c*ACC_WIDTH +: ACC_WIDTH];
      assign sum = a + b;
      assign ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
      assign s1_wdata[c*ACC_WIDTH +: ACC_WIDTH] =
         s1_drain_q                 ? '0 :
         !s1_mode_q                 ? b  :
         ((SATURATE != 0) && ovf)   ? (a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) :
                                      sum;
      assign col_sat[c] = (SATURATE != 0) && !s1_drain_q && s1_mode_q && ovf;
   end

   // the sweep owns the write port while clearing and overwrites everything anyway
   assign s1_we     = s1_valid_q && !(s1_drain_q && !s1_clear_q) && (state_q == ST_IDLE);
   assign sat_event = s1_valid_q && (state_q == ST_IDLE) && (|col_sat);

   assign out_valid_d = s1_valid_q && s1_drain_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         if (out_valid_d) out_data_q <= old_data;
         if (clr_start)      sat_q <= 1'b0;
         else if (sat_event) sat_q <= 1'b1;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sat_flag  = sat_q;

endmodule
